multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// ---- multicycle_control_unit: multicycle MIPS-style control FSM ----
// ---- rev 1.0: initial release                                    ----
`default_nettype none

module multicycle_control_unit #(
  parameter int ALUOP_W       = 3,
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opCode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemReadEn,
  output logic               MemWriteEn,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWriteEn,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IMMEX  = 4'd9;
  localparam logic [3:0] S_IMMWB  = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;

  logic [3:0] cur_state;
  logic [3:0] nxt_state;
  logic [3:0] out_state;
  logic       mem_ok;
  logic       funct_ok;
  logic [2:0] funct_op;
  logic [2:0] alu_op;
  logic       retire;

  assign mem_ok = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  always_comb begin
    funct_ok = 1'b1;
    funct_op = ALU_ADD;
    case (funct)
      6'h20:   funct_op = ALU_ADD;
      6'h22:   funct_op = ALU_SUB;
      6'h24:   funct_op = ALU_AND;
      6'h25:   funct_op = ALU_OR;
      6'h27:   funct_op = ALU_NOR;
      6'h2A:   funct_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= S_FETCH;
      instr_count <= '0;
    end else begin
      cur_state <= nxt_state;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opCode)
          OP_RTYPE:              nxt_state = S_EXEC;
          OP_LW, OP_SW:          nxt_state = S_MEMADR;
          OP_BEQ, OP_BNE:        nxt_state = S_BRANCH;
          OP_ADDI, OP_ANDI,
          OP_ORI:                nxt_state = S_IMMEX;
          OP_J:                  nxt_state = S_JUMP;
          default:               nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: nxt_state = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt_state = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt_state = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt_state = funct_ok ? S_ALUWB : S_FETCH;
      S_IMMEX:  nxt_state = S_IMMWB;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Illegal returns come from DECODE/EXEC, so they never count as retirement.
  assign retire = (nxt_state == S_FETCH) &&
                  (cur_state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP});

  // Reset forces the FETCH view so outputs are defined before the first edge.
  assign out_state = rst ? S_FETCH : cur_state;
  assign state     = out_state;
  assign ALUOp     = ALUOP_W'(alu_op);

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemReadEn  = 1'b0;
    MemWriteEn = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWriteEn = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    PCSource   = 2'd0;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (out_state)
      S_FETCH: begin
        MemReadEn = 1'b1;
        ALUSrcB   = 2'd1;
        IRWrite   = mem_ok & ~rst;
        PCWrite   = mem_ok & ~rst;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        illegal = !(opCode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                                   OP_ADDI, OP_ANDI, OP_ORI, OP_J});
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_MEMRD: begin
        MemReadEn = 1'b1;
        IorD      = 1'b1;
      end
      S_MEMWB: begin
        RegWriteEn = 1'b1;
        MemtoReg   = 1'b1;
      end
      S_MEMWR: begin
        MemWriteEn = 1'b1;
        IorD       = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        alu_op  = funct_op;
        illegal = ~funct_ok;
      end
      S_ALUWB: begin
        RegWriteEn = 1'b1;
        RegDst     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        alu_op   = ALU_SUB;
        PCSource = 2'd1;
        PCWrite  = (opCode == OP_BEQ) ? zero : ~zero;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        alu_op  = (opCode == OP_ANDI) ? ALU_AND :
                  (opCode == OP_ORI)  ? ALU_OR  : ALU_ADD;
      end
      S_IMMWB:  RegWriteEn = 1'b1;
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: per-cycle stimulus and expected outputs are queued, then replayed and compared.
`default_nettype none

module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2, mr2;
  logic [5:0] opCode, funct;
  logic       zero, mem_ready;
  assign mr2 = 1'b0;

  logic       PCWrite, IRWrite, IorD, MemReadEn, MemWriteEn, MemtoReg, RegDst, RegWriteEn, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic       illegal;
  logic [31:0] instr_count;

  logic       PCWrite2, IRWrite2, IorD2, MemReadEn2, MemWriteEn2, MemtoReg2, RegDst2, RegWriteEn2, ALUSrcA2;
  logic [1:0] ALUSrcB2, PCSource2;
  logic [5:0] ALUOp2;
  logic [3:0] state2;
  logic       illegal2;
  logic [1:0] instr_count2;

  multicycle_control_unit #(.ALUOP_W(3), .MEM_HANDSHAKE(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemReadEn(MemReadEn),
    .MemWriteEn(MemWriteEn), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWriteEn(RegWriteEn),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  multicycle_control_unit #(.ALUOP_W(6), .MEM_HANDSHAKE(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .opCode(opCode), .funct(funct), .zero(zero), .mem_ready(mr2),
    .PCWrite(PCWrite2), .IRWrite(IRWrite2), .IorD(IorD2), .MemReadEn(MemReadEn2),
    .MemWriteEn(MemWriteEn2), .MemtoReg(MemtoReg2), .RegDst(RegDst2), .RegWriteEn(RegWriteEn2),
    .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .PCSource(PCSource2), .ALUOp(ALUOp2),
    .state(state2), .illegal(illegal2), .instr_count(instr_count2)
  );

  logic [20:0] obs1;
  logic [23:0] obs2;
  assign obs1 = {state, PCWrite, IRWrite, IorD, MemReadEn, MemWriteEn, MemtoReg, RegDst,
                 RegWriteEn, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal};
  assign obs2 = {ALUOp2[5:3], state2, PCWrite2, IRWrite2, IorD2, MemReadEn2, MemWriteEn2,
                 MemtoReg2, RegDst2, RegWriteEn2, ALUSrcA2, ALUSrcB2, PCSource2, ALUOp2[2:0], illegal2};

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [20:0] exp;
    logic [31:0] cnt;
  } rec_t;

  rec_t        sbq[$];
  int          tests = 0;
  int          failed = 0;
  logic [31:0] exp_cnt = 0;
  logic        prev_rst = 1'b1;
  logic [3:0]  prev_st = 4'd0;

  // Expected control word for one cycle, taken from the state table.
  function automatic logic [20:0] exp_out(input logic r, input logic [3:0] st_in,
                                          input logic [5:0] op, input logic [5:0] fn,
                                          input logic z, input logic mr_in);
    logic [3:0] st;
    logic pcw, irw, iord, mrd, mw, m2r, rd, rw, sa, ill, mr;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    st = r ? 4'd0 : st_in;
    mr = r ? 1'b0 : mr_in;
    {pcw, irw, iord, mrd, mw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'd0; ps = 2'd0; ao = 3'd0;
    case (st)
      4'd0:  begin mrd = 1; sb = 2'd1; irw = mr; pcw = mr; end
      4'd1:  begin sb = 2'd3;
                   ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02}); end
      4'd2:  begin sa = 1; sb = 2'd2; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin sa = 1;
                   case (fn)
                     6'h20: ao = 3'd0;
                     6'h22: ao = 3'd1;
                     6'h24: ao = 3'd2;
                     6'h25: ao = 3'd3;
                     6'h27: ao = 3'd5;
                     6'h2A: ao = 3'd4;
                     default: ill = 1;
                   endcase end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; ao = 3'd1; ps = 2'd1; pcw = (op == 6'h04) ? z : ~z; end
      4'd9:  begin sa = 1; sb = 2'd2; ao = (op == 6'h0C) ? 3'd2 : (op == 6'h0D) ? 3'd3 : 3'd0; end
      4'd10: rw = 1;
      4'd11: begin pcw = 1; ps = 2'd2; end
      default: ;
    endcase
    return {st, pcw, irw, iord, mrd, mw, m2r, rd, rw, sa, sb, ps, ao, ill};
  endfunction

  task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [3:0] st);
    rec_t e;
    if (prev_rst) exp_cnt = 0;
    else if (st == 4'd0 && (prev_st inside {4'd4, 4'd5, 4'd7, 4'd8, 4'd10, 4'd11})) exp_cnt = exp_cnt + 1;
    e.r = r; e.op = op; e.fn = fn; e.z = z; e.mr = mr;
    e.exp = exp_out(r, st, op, fn, z, mr);
    e.cnt = exp_cnt;
    prev_rst = r;
    prev_st = r ? 4'd0 : st;
    sbq.push_back(e);
  endtask

  task automatic test_reset;
    rec_t e;
    int i = 0;
    push(1, 6'h00, 6'h20, 0, 1, 0);
    push(1, 6'h00, 6'h20, 0, 1, 0);
    push(0, 6'h00, 6'h20, 0, 0, 0);
    push(0, 6'h00, 6'h20, 0, 0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.r; opCode = e.op; funct = e.fn; zero = e.z; mem_ready = e.mr;
      @(negedge clk);
      tests++;
      if (obs1 !== e.exp) begin failed++; $display("FAIL reset[%0d] controls: got %h, expected %h", i, obs1, e.exp); end
      tests++;
      if (instr_count !== e.cnt) begin failed++; $display("FAIL reset[%0d] instr_count: got %0d, expected %0d", i, instr_count, e.cnt); end
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic test_rtype;
    rec_t e;
    int i = 0;
    push(0, 6'h00, 6'h22, 0, 1, 0); push(0, 6'h00, 6'h22, 0, 0, 1);
    push(0, 6'h00, 6'h22, 0, 0, 6); push(0, 6'h00, 6'h22, 0, 0, 7);
    push(0, 6'h00, 6'h2A, 0, 1, 0); push(0, 6'h00, 6'h2A, 0, 0, 1);
    push(0, 6'h00, 6'h2A, 0, 0, 6); push(0, 6'h00, 6'h2A, 0, 0, 7);
    push(0, 6'h00, 6'h20, 0, 0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.r; opCode = e.op; funct = e.fn; zero = e.z; mem_ready = e.mr;
      @(negedge clk);
      tests++;
      if (obs1 !== e.exp) begin failed++; $display("FAIL rtype[%0d] controls: got %h, expected %h", i, obs1, e.exp); end
      tests++;
      if (instr_count !== e.cnt) begin failed++; $display("FAIL rtype[%0d] instr_count: got %0d, expected %0d", i, instr_count, e.cnt); end
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic test_memory;
    rec_t e;
    int i = 0;
    push(0, 6'h23, 0, 0, 0, 0); push(0, 6'h23, 0, 0, 1, 0);
    push(0, 6'h23, 0, 0, 0, 1); push(0, 6'h23, 0, 0, 0, 2);
    for (int k = 0; k < 3; k++) push(0, 6'h23, 0, 0, 0, 3);
    push(0, 6'h23, 0, 0, 1, 3); push(0, 6'h23, 0, 0, 0, 4);
    push(0, 6'h2B, 0, 0, 1, 0); push(0, 6'h2B, 0, 0, 0, 1);
    push(0, 6'h2B, 0, 0, 0, 2); push(0, 6'h2B, 0, 0, 0, 5);
    push(0, 6'h2B, 0, 0, 1, 5); push(0, 6'h2B, 0, 0, 0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.r; opCode = e.op; funct = e.fn; zero = e.z; mem_ready = e.mr;
      @(negedge clk);
      tests++;
      if (obs1 !== e.exp) begin failed++; $display("FAIL memory[%0d] controls: got %h, expected %h", i, obs1, e.exp); end
      tests++;
      if (instr_count !== e.cnt) begin failed++; $display("FAIL memory[%0d] instr_count: got %0d, expected %0d", i, instr_count, e.cnt); end
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic test_branch;
    rec_t e;
    int i = 0;
    logic [5:0] ops[3];
    logic       zs[3];
    ops = '{6'h04, 6'h05, 6'h04};
    zs  = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      push(0, ops[k], 0, zs[k], 1, 0); push(0, ops[k], 0, zs[k], 0, 1);
      push(0, ops[k], 0, zs[k], 0, 8);
    end
    push(0, 6'h04, 0, 0, 0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.r; opCode = e.op; funct = e.fn; zero = e.z; mem_ready = e.mr;
      @(negedge clk);
      tests++;
      if (obs1 !== e.exp) begin failed++; $display("FAIL branch[%0d] controls: got %h, expected %h", i, obs1, e.exp); end
      tests++;
      if (instr_count !== e.cnt) begin failed++; $display("FAIL branch[%0d] instr_count: got %0d, expected %0d", i, instr_count, e.cnt); end
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic test_imm_jump;
    rec_t e;
    int i = 0;
    logic [5:0] ops[3];
    ops = '{6'h0D, 6'h08, 6'h0C};
    for (int k = 0; k < 3; k++) begin
      push(0, ops[k], 0, 0, 1, 0); push(0, ops[k], 0, 0, 0, 1);
      push(0, ops[k], 0, 0, 0, 9); push(0, ops[k], 0, 0, 0, 10);
    end
    push(0, 6'h02, 0, 0, 1, 0); push(0, 6'h02, 0, 0, 0, 1);
    push(0, 6'h02, 0, 0, 0, 11); push(0, 6'h02, 0, 0, 0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.r; opCode = e.op; funct = e.fn; zero = e.z; mem_ready = e.mr;
      @(negedge clk);
      tests++;
      if (obs1 !== e.exp) begin failed++; $display("FAIL immjump[%0d] controls: got %h, expected %h", i, obs1, e.exp); end
      tests++;
      if (instr_count !== e.cnt) begin failed++; $display("FAIL immjump[%0d] instr_count: got %0d, expected %0d", i, instr_count, e.cnt); end
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic test_illegal;
    rec_t e;
    int i = 0;
    push(0, 6'h3F, 0, 0, 1, 0); push(0, 6'h3F, 0, 0, 0, 1);
    push(0, 6'h00, 6'h00, 0, 1, 0); push(0, 6'h00, 6'h00, 0, 0, 1);
    push(0, 6'h00, 6'h00, 0, 0, 6); push(0, 6'h00, 6'h00, 0, 0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.r; opCode = e.op; funct = e.fn; zero = e.z; mem_ready = e.mr;
      @(negedge clk);
      tests++;
      if (obs1 !== e.exp) begin failed++; $display("FAIL illegal[%0d] controls: got %h, expected %h", i, obs1, e.exp); end
      tests++;
      if (instr_count !== e.cnt) begin failed++; $display("FAIL illegal[%0d] instr_count: got %0d, expected %0d", i, instr_count, e.cnt); end
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic test_reset_mid;
    rec_t e;
    int i = 0;
    push(0, 6'h2B, 0, 0, 1, 0); push(0, 6'h2B, 0, 0, 0, 1);
    push(0, 6'h2B, 0, 0, 0, 2); push(0, 6'h2B, 0, 0, 0, 5);
    push(1, 6'h2B, 0, 0, 0, 5); push(0, 6'h2B, 0, 0, 0, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst = e.r; opCode = e.op; funct = e.fn; zero = e.z; mem_ready = e.mr;
      @(negedge clk);
      tests++;
      if (obs1 !== e.exp) begin failed++; $display("FAIL reset_mid[%0d] controls: got %h, expected %h", i, obs1, e.exp); end
      tests++;
      if (instr_count !== e.cnt) begin failed++; $display("FAIL reset_mid[%0d] instr_count: got %0d, expected %0d", i, instr_count, e.cnt); end
      @(posedge clk); #1;
      i++;
    end
  endtask

  // Second instance: no handshake (mem_ready tied low), 6-bit ALUOp, 2-bit wrapping counter.
  task automatic test_no_handshake;
    rec_t e;
    int i = 0;
    exp_cnt = 0; prev_rst = 1'b1; prev_st = 4'd0;
    push(1, 6'h23, 0, 0, 1, 0);
    push(0, 6'h23, 0, 0, 1, 0); push(0, 6'h23, 0, 0, 1, 1);
    push(0, 6'h23, 0, 0, 1, 2); push(0, 6'h23, 0, 0, 1, 3); push(0, 6'h23, 0, 0, 1, 4);
    push(0, 6'h00, 6'h22, 0, 1, 0); push(0, 6'h00, 6'h22, 0, 1, 1);
    push(0, 6'h00, 6'h22, 0, 1, 6); push(0, 6'h00, 6'h22, 0, 1, 7);
    for (int k = 0; k < 2; k++) begin
      push(0, 6'h02, 0, 0, 1, 0); push(0, 6'h02, 0, 0, 1, 1); push(0, 6'h02, 0, 0, 1, 11);
    end
    push(0, 6'h02, 0, 0, 1, 0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst2 = e.r; opCode = e.op; funct = e.fn; zero = e.z;
      @(negedge clk);
      tests++;
      if (obs2 !== {3'b000, e.exp}) begin failed++; $display("FAIL nohs[%0d] controls: got %h, expected %h", i, obs2, {3'b000, e.exp}); end
      tests++;
      if (instr_count2 !== e.cnt[1:0]) begin failed++; $display("FAIL nohs[%0d] instr_count: got %0d, expected %0d", i, instr_count2, e.cnt[1:0]); end
      @(posedge clk); #1;
      i++;
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    opCode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_rtype;
    test_memory;
    test_branch;
    test_imm_jump;
    test_illegal;
    test_reset_mid;
    test_no_handshake;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
